// File: rtl/tridiag_matvec_if.sv
// Request/result bundle of the tridiagonal matrix-vector engine.
// The master side issues operands and accepts groups; the engine is the slave.
interface tridiag_matvec_if #(
    parameter int N_EQN = 10,
    parameter int W     = 32,
    parameter int LANES = 4
);
    localparam int NGRP = (N_EQN + LANES - 1) / LANES;
    localparam int GW   = $clog2(NGRP) + 1;

    logic                     start;
    logic [W*(3*N_EQN-2)-1:0] mat;
    logic [W*N_EQN-1:0]       vector;
    logic                     out_ready;
    logic                     busy;
    logic                     out_valid;
    logic [W*LANES-1:0]       out_data;
    logic [GW-1:0]            out_group;
    logic [LANES-1:0]         out_mask;
    logic                     done;

    modport master (
        output start, mat, vector, out_ready,
        input  busy, out_valid, out_data, out_group, out_mask, done
    );

    modport slave (
        input  start, mat, vector, out_ready,
        output busy, out_valid, out_data, out_group, out_mask, done
    );
endinterface

// File: rtl/tridiag_matvec_engine.sv
// Tridiagonal matrix times vector, LANES rows per group through a two-stage
// multiply/sum pipeline with a valid/ready output handshake and backpressure.
module tridiag_matvec_engine #(
    parameter int N_EQN = 10,
    parameter int W     = 32,
    parameter int LANES = 4
) (
    input logic             clk,
    input logic             reset,
    tridiag_matvec_if.slave bus
);
    localparam int NGRP = (N_EQN + LANES - 1) / LANES;
    localparam int GW   = $clog2(NGRP) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    // Operand slot k of a lane: 0 = sub-diagonal term, 1 = diagonal, 2 = super-diagonal.
    typedef logic [NGRP-1:0][LANES-1:0][2:0][W-1:0] opnd_t;
    typedef logic [LANES-1:0][2:0][W-1:0]           lane_opnd_t;

    state_t                  state;
    logic                    busy_r;
    logic                    done_r;
    logic [GW-1:0]           issue_cnt;
    opnd_t                   pad_a;
    opnd_t                   pad_x;
    opnd_t                   op_a;
    opnd_t                   op_x;
    lane_opnd_t              sel_a;
    lane_opnd_t              sel_x;
    logic                    stall;
    logic                    issue;
    logic                    xfer;

    lane_opnd_t              prod_p1;
    logic                    vld_p1;
    logic [GW-1:0]           grp_p1;

    logic [LANES-1:0][W-1:0] data_p2;
    logic                    vld_p2;
    logic [GW-1:0]           grp_p2;
    logic [LANES-1:0]        mask_p2;

    function automatic logic signed [W-1:0] wrap_mul(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
        logic signed [2*W-1:0] full;
        full = (2*W)'(a) * (2*W)'(b);
        return full[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] wrap_add3(input logic signed [W-1:0] a,
                                                      input logic signed [W-1:0] b,
                                                      input logic signed [W-1:0] c);
        return a + b + c;
    endfunction

    function automatic logic [LANES-1:0] row_mask(input logic [GW-1:0] g);
        logic [LANES-1:0] m;
        for (int j = 0; j < LANES; j++)
            m[j] = (int'(g) * LANES + j) < N_EQN;
        return m;
    endfunction

    // Out-of-range band terms become zero coefficient and zero operand, so padded
    // rows and the matrix edges need no special handling further down.
    always_comb begin
        int r;
        int c;
        int mi;
        pad_a = '0;
        pad_x = '0;
        r     = 0;
        c     = 0;
        mi    = 0;
        for (int g = 0; g < NGRP; g++) begin
            for (int j = 0; j < LANES; j++) begin
                for (int k = 0; k < 3; k++) begin
                    r = g * LANES + j;
                    c = r + k - 1;
                    if (r < N_EQN && c >= 0 && c < N_EQN) begin
                        mi = 3 * r + k - 1;
                        pad_a[g][j][k] = bus.mat[W*mi +: W];
                        pad_x[g][j][k] = bus.vector[W*c +: W];
                    end
                end
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_x = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (issue_cnt == GW'(g)) begin
                sel_a = op_a[g];
                sel_x = op_x[g];
            end
        end
    end

    assign stall = vld_p2 && !bus.out_ready;
    assign xfer  = vld_p2 && bus.out_ready;
    assign issue = (state == RUN) && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            issue_cnt <= '0;
            vld_p1    <= 1'b0;
            grp_p1    <= '0;
            prod_p1   <= '0;
            vld_p2    <= 1'b0;
            grp_p2    <= '0;
            mask_p2   <= '0;
            data_p2   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= LOAD;
                        busy_r <= 1'b1;
                    end
                end
                LOAD: begin
                    op_a      <= pad_a;
                    op_x      <= pad_x;
                    issue_cnt <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (!stall) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == GW'(NGRP - 1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer && grp_p2 == GW'(NGRP - 1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // ---- stage 1: 3*LANES products of the issued group ----
            if (!stall) begin
                vld_p1 <= issue;
                grp_p1 <= issue ? issue_cnt : '0;
                for (int j = 0; j < LANES; j++)
                    for (int k = 0; k < 3; k++)
                        prod_p1[j][k] <= issue ? wrap_mul(sel_a[j][k], sel_x[j][k]) : '0;

                // ---- stage 2: row sums into the output register ----
                vld_p2  <= vld_p1;
                grp_p2  <= grp_p1;
                mask_p2 <= vld_p1 ? row_mask(grp_p1) : '0;
                for (int j = 0; j < LANES; j++)
                    data_p2[j] <= vld_p1 ? wrap_add3(prod_p1[j][0], prod_p1[j][1], prod_p1[j][2]) : '0;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_valid = vld_p2;
    assign bus.out_data  = data_p2;
    assign bus.out_group = grp_p2;
    assign bus.out_mask  = mask_p2;
endmodule

// File: tb/tb_tridiag_matvec_engine.sv
// Bench for the tridiagonal engine: directed scenarios on a 5-row/2-lane instance
// and random operands on a 4-row/4-lane instance, checked against a plain-arithmetic model.
module tb_tridiag_matvec_engine;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    tridiag_matvec_if #(.N_EQN(5), .W(16), .LANES(2)) bus_a ();
    tridiag_matvec_if #(.N_EQN(4), .W(16), .LANES(4)) bus_b ();

    tridiag_matvec_engine #(.N_EQN(5), .W(16), .LANES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    tridiag_matvec_engine #(.N_EQN(4), .W(16), .LANES(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    typedef struct {
        logic [31:0] data;
        logic [2:0]  grp;
        logic [1:0]  mask;
    } grp_t;

    grp_t        expq[$];
    logic [15:0] ma[16];
    logic [15:0] xa[8];
    logic [15:0] mb[16];
    logic [15:0] xb[8];
    logic [31:0] prev_data = '0;
    bit          prev_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
        end
    endtask

    // y[r] straight from the band definition, products summed exactly then reduced mod 2^16.
    function automatic logic [15:0] tri_y(input int n, input int r,
                                          input logic [15:0] m[16], input logic [15:0] x[8]);
        longint acc = 0;
        for (int c = r - 1; c <= r + 1; c++)
            if (r < n && c >= 0 && c < n)
                acc += longint'($signed(m[2*r+c])) * longint'($signed(x[c]));
        return acc[15:0];
    endfunction

    task automatic pack_a();
        for (int k = 0; k < 13; k++) bus_a.mat[16*k +: 16] = ma[k];
        for (int r = 0; r < 5; r++)  bus_a.vector[16*r +: 16] = xa[r];
    endtask

    task automatic fill_expected();
        grp_t e;
        expq.delete();
        for (int g = 0; g < 3; g++) begin
            e.data = '0;
            e.mask = '0;
            e.grp  = 3'(g);
            for (int j = 0; j < 2; j++) begin
                if (2*g + j < 5) begin
                    e.data[16*j +: 16] = tri_y(5, 2*g + j, ma, xa);
                    e.mask[j] = 1'b1;
                end
            end
            expq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.out_valid === 1'b1) begin
            if (prev_stall) check("stall_hold_data", bus_a.out_data, prev_data);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_group: got group %0d, required none", bus_a.out_group);
            end else begin
                check("group_data", bus_a.out_data, expq[0].data);
                check("group_index", bus_a.out_group, expq[0].grp);
                check("group_mask", bus_a.out_mask, expq[0].mask);
                if (bus_a.out_ready) void'(expq.pop_front());
            end
            prev_stall <= !bus_a.out_ready;
            prev_data  <= bus_a.out_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic run_a(output int done_cyc, output int first_vld, output logic [31:0] first_data);
        done_cyc   = -1;
        first_vld  = -1;
        first_data = '0;
        @(posedge clk); #1 bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) check("busy_after_start", bus_a.busy, 1);
            if (first_vld < 0 && bus_a.out_valid === 1'b1) begin
                first_vld  = n;
                first_data = bus_a.out_data;
            end
            if (bus_a.done === 1'b1) begin
                done_cyc = n;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got no done within 200 cycles, required done");
        end
    endtask

    // Called at the done cycle: also pulses start there, which must be ignored.
    task automatic post_run(input int done_cyc, input int want_cyc, input string tag);
        check({tag, "_done_cycles"}, done_cyc, want_cyc);
        bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        @(negedge clk);
        check({tag, "_done_single_pulse"}, bus_a.done, 0);
        check({tag, "_busy_after_done"}, bus_a.busy, 0);
        @(negedge clk);
        check({tag, "_start_in_done_ignored"}, bus_a.busy, 0);
        check({tag, "_all_groups_delivered"}, expq.size(), 0);
    endtask

    task automatic run_b(input string tag);
        logic [63:0] ey;
        int nvld;
        int dc;
        for (int k = 0; k < 16; k++) mb[k] = (k < 10) ? 16'($urandom) : 16'h0;
        for (int r = 0; r < 8; r++)  xb[r] = (r < 4) ? 16'($urandom) : 16'h0;
        for (int k = 0; k < 10; k++) bus_b.mat[16*k +: 16] = mb[k];
        for (int r = 0; r < 4; r++)  bus_b.vector[16*r +: 16] = xb[r];
        for (int r = 0; r < 4; r++)  ey[16*r +: 16] = tri_y(4, r, mb, xb);
        nvld = 0;
        dc   = -1;
        @(posedge clk); #1 bus_b.start = 1'b1;
        @(posedge clk); #1 bus_b.start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus_b.out_valid === 1'b1) begin
                nvld++;
                check({tag, "_data"}, bus_b.out_data, ey);
                check({tag, "_group"}, bus_b.out_group, 0);
                check({tag, "_mask"}, bus_b.out_mask, 4'hF);
            end
            if (bus_b.done === 1'b1) begin
                dc = n;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_done_cycles"}, dc, 5);
        check({tag, "_group_count"}, nvld, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int fv;
        logic [31:0] fd;

        bus_a.start = 1'b0; bus_a.out_ready = 1'b1; bus_a.mat = '0; bus_a.vector = '0;
        bus_b.start = 1'b0; bus_b.out_ready = 1'b1; bus_b.mat = '0; bus_b.vector = '0;
        for (int k = 0; k < 16; k++) begin ma[k] = '0; mb[k] = '0; end
        for (int k = 0; k < 8; k++)  begin xa[k] = '0; xb[k] = '0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", bus_a.busy, 0);
        check("reset_out_valid", bus_a.out_valid, 0);
        check("reset_done", bus_a.done, 0);
        check("reset_out_data", bus_a.out_data, 0);
        check("reset_out_group", bus_a.out_group, 0);
        check("reset_out_mask", bus_a.out_mask, 0);

        // Basic product: all ones band, x = 1..5 -> 3 6 9 12 9
        for (int k = 0; k < 13; k++) ma[k] = 16'd1;
        for (int r = 0; r < 5; r++)  xa[r] = 16'(r + 1);
        check("model_basic_y0", tri_y(5, 0, ma, xa), 3);
        check("model_basic_y1", tri_y(5, 1, ma, xa), 6);
        check("model_basic_y2", tri_y(5, 2, ma, xa), 9);
        check("model_basic_y3", tri_y(5, 3, ma, xa), 12);
        check("model_basic_y4", tri_y(5, 4, ma, xa), 9);
        pack_a();
        fill_expected();
        run_a(dc, fv, fd);
        check("basic_first_valid_cycle", fv, 4);
        check("basic_group0_literal", fd, {16'd6, 16'd3});
        post_run(dc, 7, "basic");

        // Backpressure: out_ready low for the first 4 valid cycles
        fill_expected();
        fork
            run_a(dc, fv, fd);
            begin
                repeat (5) @(posedge clk);
                #1 bus_a.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus_a.out_ready = 1'b1;
            end
        join
        check("bp_first_valid_cycle", fv, 4);
        post_run(dc, 11, "bp");

        // Wrap: 0x7FFF * 2 truncates to 0xFFFE
        for (int k = 0; k < 16; k++) ma[k] = '0;
        for (int r = 0; r < 8; r++)  xa[r] = '0;
        ma[0] = 16'h7FFF;
        xa[0] = 16'd2;
        check("model_wrap_y0", tri_y(5, 0, ma, xa), 16'hFFFE);
        pack_a();
        fill_expected();
        run_a(dc, fv, fd);
        check("wrap_lane0_literal", fd[15:0], 16'hFFFE);
        post_run(dc, 7, "wrap");

        // Operands changed and start re-pulsed after LOAD: original operands must win
        for (int k = 0; k < 13; k++) ma[k] = 16'(k + 1);
        xa[0] = 16'd3; xa[1] = 16'hFFFE; xa[2] = 16'd5; xa[3] = 16'h7FFF; xa[4] = 16'hFFFF;
        pack_a();
        fill_expected();
        fork
            run_a(dc, fv, fd);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus_a.mat    = {13{16'h0007}};
                bus_a.vector = {5{16'h0003}};
                bus_a.start  = 1'b1;
                @(posedge clk); #1 bus_a.start = 1'b0;
            end
        join
        post_run(dc, 7, "late_change");

        // Reset while draining the last group
        for (int k = 0; k < 13; k++) ma[k] = 16'd1;
        for (int r = 0; r < 5; r++)  xa[r] = 16'(r + 1);
        pack_a();
        fill_expected();
        @(posedge clk); #1 bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus_a.out_ready = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        expq.delete();
        @(negedge clk);
        check("rst_drain_busy", bus_a.busy, 0);
        check("rst_drain_out_valid", bus_a.out_valid, 0);
        check("rst_drain_out_data", bus_a.out_data, 0);
        check("rst_drain_out_mask", bus_a.out_mask, 0);
        bus_a.out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("rst_drain_no_done", bus_a.done, 0);
            check("rst_drain_no_valid", bus_a.out_valid, 0);
        end
        fill_expected();
        run_a(dc, fv, fd);
        post_run(dc, 7, "after_reset");

        // Reset has priority over a simultaneous start
        @(posedge clk); #1 begin reset = 1'b1; bus_a.start = 1'b1; end
        @(posedge clk); #1 begin reset = 1'b0; bus_a.start = 1'b0; end
        @(negedge clk);
        check("reset_over_start_busy", bus_a.busy, 0);
        @(negedge clk);
        check("reset_over_start_idle", bus_a.busy, 0);

        // Single-group instance with random signed operands
        run_b("single_grp0");
        run_b("single_grp1");
        run_b("single_grp2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
